// File: rtl/trap_unit.sv
// Trap sequencer between commit and the CSR block: accepts exceptions, mret and
// interrupts, stalls commit through a fixed flush window, then emits one redirect.
module trap_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int SQN_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_excValid,
    input  logic [3:0]       IN_excCause,
    input  logic [31:0]      IN_excPC,
    input  logic [SQN_W-1:0] IN_excSqN,
    input  logic             IN_mret,
    input  logic [SQN_W-1:0] IN_mretSqN,
    input  logic [31:0]      IN_mepc,
    input  logic [2:0]       IN_irq,
    input  logic             IN_mie,
    input  logic [31:0]      IN_nextPC,
    input  logic [SQN_W-1:0] IN_nextSqN,
    input  logic             IN_vectored,
    input  logic [29:0]      IN_tvec,
    output logic             OUT_stall,
    output logic             OUT_branchTaken,
    output logic [31:0]      OUT_branchPC,
    output logic [SQN_W-1:0] OUT_branchSqN,
    output logic             OUT_trapValid,
    output logic [3:0]       OUT_trapCause,
    output logic             OUT_trapIsInt,
    output logic [31:0]      OUT_trapPC
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
    typedef enum logic [1:0] {KIND_EXC, KIND_MRET, KIND_INT} kind_t;

    state_t           state;
    kind_t            kind;
    logic [3:0]       cnt;
    logic [3:0]       cause;
    logic             is_int;
    logic [31:0]      trap_pc;
    logic [31:0]      target;
    logic [SQN_W-1:0] sqn;

    logic             irq_take;
    logic [3:0]       irq_cause;
    logic [31:0]      tvec_base;
    logic [31:0]      irq_target;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        irq_cause = 4'd7;
        if (IN_irq[2])      irq_cause = 4'd11;
        else if (IN_irq[1]) irq_cause = 4'd3;
    end

    assign irq_take   = IN_mie && (IN_irq != 3'b000);
    assign tvec_base  = {IN_tvec, 2'b00};
    assign irq_target = tvec_base + (IN_vectored ? {26'b0, irq_cause, 2'b00} : 32'b0);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            kind            <= KIND_EXC;
            cnt             <= 4'd0;
            cause           <= 4'd0;
            is_int          <= 1'b0;
            trap_pc         <= 32'b0;
            target          <= 32'b0;
            sqn             <= '0;
            OUT_stall       <= 1'b0;
            OUT_branchTaken <= 1'b0;
            OUT_branchPC    <= 32'b0;
            OUT_branchSqN   <= '0;
            OUT_trapValid   <= 1'b0;
            OUT_trapCause   <= 4'd0;
            OUT_trapIsInt   <= 1'b0;
            OUT_trapPC      <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Priority: exception > mret > interrupt; losers are simply dropped.
                    if (IN_excValid) begin
                        kind    <= KIND_EXC;
                        cause   <= IN_excCause;
                        is_int  <= 1'b0;
                        trap_pc <= IN_excPC;
                        target  <= tvec_base;
                        sqn     <= IN_excSqN;
                    end else if (IN_mret) begin
                        kind    <= KIND_MRET;
                        cause   <= 4'd0;
                        is_int  <= 1'b0;
                        trap_pc <= 32'b0;
                        target  <= IN_mepc;
                        sqn     <= IN_mretSqN;
                    end else if (irq_take) begin
                        kind    <= KIND_INT;
                        cause   <= irq_cause;
                        is_int  <= 1'b1;
                        trap_pc <= IN_nextPC;
                        target  <= irq_target;
                        sqn     <= IN_nextSqN - SQN_W'(1);
                    end
                    if (IN_excValid || IN_mret || irq_take) begin
                        state     <= FLUSH;
                        cnt       <= 4'(FLUSH_CYCLES - 1);
                        OUT_stall <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state           <= REDIRECT;
                        OUT_branchTaken <= 1'b1;
                        OUT_branchPC    <= target;
                        OUT_branchSqN   <= sqn;
                        if (kind != KIND_MRET) begin
                            OUT_trapValid <= 1'b1;
                            OUT_trapCause <= cause;
                            OUT_trapIsInt <= is_int;
                            OUT_trapPC    <= trap_pc;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    state           <= IDLE;
                    OUT_stall       <= 1'b0;
                    OUT_branchTaken <= 1'b0;
                    OUT_branchPC    <= 32'b0;
                    OUT_branchSqN   <= '0;
                    OUT_trapValid   <= 1'b0;
                    OUT_trapCause   <= 4'd0;
                    OUT_trapIsInt   <= 1'b0;
                    OUT_trapPC      <= 32'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit with hand-computed expected values.
module tb_trap_unit;

    localparam int FLUSH_CYCLES = 2;
    localparam int SQN_W        = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             IN_excValid;
    logic [3:0]       IN_excCause;
    logic [31:0]      IN_excPC;
    logic [SQN_W-1:0] IN_excSqN;
    logic             IN_mret;
    logic [SQN_W-1:0] IN_mretSqN;
    logic [31:0]      IN_mepc;
    logic [2:0]       IN_irq;
    logic             IN_mie;
    logic [31:0]      IN_nextPC;
    logic [SQN_W-1:0] IN_nextSqN;
    logic             IN_vectored;
    logic [29:0]      IN_tvec;
    logic             OUT_stall;
    logic             OUT_branchTaken;
    logic [31:0]      OUT_branchPC;
    logic [SQN_W-1:0] OUT_branchSqN;
    logic             OUT_trapValid;
    logic [3:0]       OUT_trapCause;
    logic             OUT_trapIsInt;
    logic [31:0]      OUT_trapPC;

    int checks = 0;
    int errors = 0;
    bit trap_seen;

    trap_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .SQN_W(SQN_W)) dut (
        .clk(clk), .rst(rst),
        .IN_excValid(IN_excValid), .IN_excCause(IN_excCause), .IN_excPC(IN_excPC),
        .IN_excSqN(IN_excSqN), .IN_mret(IN_mret), .IN_mretSqN(IN_mretSqN),
        .IN_mepc(IN_mepc), .IN_irq(IN_irq), .IN_mie(IN_mie),
        .IN_nextPC(IN_nextPC), .IN_nextSqN(IN_nextSqN),
        .IN_vectored(IN_vectored), .IN_tvec(IN_tvec),
        .OUT_stall(OUT_stall), .OUT_branchTaken(OUT_branchTaken),
        .OUT_branchPC(OUT_branchPC), .OUT_branchSqN(OUT_branchSqN),
        .OUT_trapValid(OUT_trapValid), .OUT_trapCause(OUT_trapCause),
        .OUT_trapIsInt(OUT_trapIsInt), .OUT_trapPC(OUT_trapPC)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Commit must never present exceptions or mret while the unit is stalling it.
    always @(negedge clk) begin
        if (rst && OUT_stall)
            check("no_event_while_stalled", {30'b0, IN_excValid, IN_mret}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One acceptance edge, then drop the one-shot commit inputs.
    task automatic accept(input string tag);
        step();
        IN_excValid = 1'b0;
        IN_mret     = 1'b0;
        check({tag, "_stall_on_accept"}, {31'b0, OUT_stall}, 32'd1);
    endtask

    // Sampled #1 after each edge: redirect is visible after the FLUSH_CYCLES-th edge
    // past acceptance, so a consumer clocking on the next edge sees it at +FLUSH_CYCLES+1.
    task automatic wait_redirect(input string tag);
        bit seen = 1'b0;
        int lat = 0;
        trap_seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            trap_seen |= OUT_trapValid;
            if (OUT_branchTaken) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            check({tag, "_stall_in_flush"}, {31'b0, OUT_stall}, 32'd1);
        end
        check({tag, "_redirect_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_latency"}, lat, FLUSH_CYCLES);
        check({tag, "_stall_in_redirect"}, {31'b0, OUT_stall}, 32'd1);
    endtask

    task automatic check_trap(input string tag, input logic [31:0] pc, input logic [31:0] sqn,
                              input logic [3:0] cause, input logic is_int, input logic [31:0] tpc);
        check({tag, "_branch_pc"}, OUT_branchPC, pc);
        check({tag, "_branch_sqn"}, {25'b0, OUT_branchSqN}, sqn);
        check({tag, "_trap_valid"}, {31'b0, OUT_trapValid}, 32'd1);
        check({tag, "_cause"}, {28'b0, OUT_trapCause}, {28'b0, cause});
        check({tag, "_is_int"}, {31'b0, OUT_trapIsInt}, {31'b0, is_int});
        check({tag, "_trap_pc"}, OUT_trapPC, tpc);
    endtask

    task automatic finish_redirect(input string tag);
        step();
        check({tag, "_branch_one_cycle"}, {31'b0, OUT_branchTaken}, 32'd0);
        check({tag, "_trap_one_cycle"}, {31'b0, OUT_trapValid}, 32'd0);
        check({tag, "_stall_released"}, {31'b0, OUT_stall}, 32'd0);
    endtask

    initial begin
        bit busy;
        rst = 1'b0;
        IN_excValid = 0; IN_excCause = 0; IN_excPC = 0; IN_excSqN = 0;
        IN_mret = 0; IN_mretSqN = 0; IN_mepc = 0; IN_irq = 0; IN_mie = 0;
        IN_nextPC = 0; IN_nextSqN = 0; IN_vectored = 0; IN_tvec = 0;
        repeat (3) step();
        check("reset_stall", {31'b0, OUT_stall}, 32'd0);
        check("reset_branch", {31'b0, OUT_branchTaken}, 32'd0);
        check("reset_trap", {31'b0, OUT_trapValid}, 32'd0);
        rst = 1'b1;
        step();

        // 1: plain exception; tvec changed after acceptance must not affect target
        IN_excValid = 1; IN_excCause = 4'd2; IN_excPC = 32'h1000; IN_excSqN = 7'd5;
        IN_tvec = 30'h10; IN_vectored = 0;
        accept("exc");
        IN_tvec = 30'h3ff;
        wait_redirect("exc");
        check_trap("exc", 32'h40, 32'd5, 4'd2, 1'b0, 32'h1000);
        finish_redirect("exc");

        // 2: vectored timer interrupt
        IN_mie = 1; IN_irq = 3'b001; IN_vectored = 1; IN_tvec = 30'h40;
        IN_nextPC = 32'h2004; IN_nextSqN = 7'd9;
        accept("tmr");
        IN_irq = 3'b000;
        wait_redirect("tmr");
        check_trap("tmr", 32'h11c, 32'd8, 4'd7, 1'b1, 32'h2004);
        finish_redirect("tmr");
        IN_mie = 0;

        // 3: mret; mepc changed after acceptance must not affect target
        IN_mret = 1; IN_mepc = 32'h3008; IN_mretSqN = 7'd12;
        accept("mret");
        IN_mepc = 32'h0;
        wait_redirect("mret");
        check("mret_branch_pc", OUT_branchPC, 32'h3008);
        check("mret_branch_sqn", {25'b0, OUT_branchSqN}, 32'd12);
        check("mret_no_trap", {31'b0, trap_seen}, 32'd0);
        finish_redirect("mret");

        // 4: exception wins over ext+timer irq; ext irq follows back-to-back
        IN_excValid = 1; IN_excCause = 4'd4; IN_excPC = 32'h500; IN_excSqN = 7'd20;
        IN_irq = 3'b101; IN_mie = 1; IN_vectored = 1; IN_tvec = 30'h40;
        IN_nextPC = 32'h504; IN_nextSqN = 7'd21;
        accept("pri");
        wait_redirect("pri");
        check_trap("pri", 32'h100, 32'd20, 4'd4, 1'b0, 32'h500);
        finish_redirect("pri");
        step();
        check("b2b_accept_first_idle", {31'b0, OUT_stall}, 32'd1);
        IN_irq = 3'b000;
        wait_redirect("b2b");
        check_trap("b2b", 32'h12c, 32'd20, 4'd11, 1'b1, 32'h504);
        finish_redirect("b2b");
        IN_mie = 0;

        // 5: masked interrupts stay silent; unmasking takes ext; sqN wraps 0 -> 127
        IN_irq = 3'b111; IN_mie = 0; IN_vectored = 0; IN_tvec = 30'h40;
        IN_nextPC = 32'h600; IN_nextSqN = 7'd0;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            busy |= OUT_stall | OUT_branchTaken | OUT_trapValid;
        end
        check("masked_quiet", {31'b0, busy}, 32'd0);
        IN_mie = 1;
        accept("unmask");
        IN_irq = 3'b000; IN_mie = 0;
        wait_redirect("unmask");
        check_trap("unmask", 32'h100, 32'd127, 4'd11, 1'b1, 32'h600);
        finish_redirect("unmask");

        // 6: reset during FLUSH aborts the trap
        IN_excValid = 1; IN_excCause = 4'd1; IN_excPC = 32'h700; IN_excSqN = 7'd3;
        accept("abort");
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_stall", {31'b0, OUT_stall}, 32'd0);
        check("abort_branch", {31'b0, OUT_branchTaken}, 32'd0);
        check("abort_trap", {31'b0, OUT_trapValid}, 32'd0);
        check("abort_pc", OUT_branchPC | OUT_trapPC, 32'd0);
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            busy |= OUT_stall | OUT_branchTaken | OUT_trapValid;
        end
        check("abort_no_redirect", {31'b0, busy}, 32'd0);
        IN_excValid = 1; IN_excCause = 4'd5; IN_excPC = 32'h800; IN_excSqN = 7'd40;
        accept("post");
        wait_redirect("post");
        check_trap("post", 32'h100, 32'd40, 4'd5, 1'b0, 32'h800);
        finish_redirect("post");

        // 7: vectored target wraps around 32 bits
        IN_mie = 1; IN_irq = 3'b100; IN_vectored = 1; IN_tvec = 30'h3fffffff;
        IN_nextPC = 32'h900; IN_nextSqN = 7'd50;
        accept("wrap");
        IN_irq = 3'b000; IN_mie = 0;
        wait_redirect("wrap");
        check_trap("wrap", 32'h28, 32'd49, 4'd11, 1'b1, 32'h900);
        finish_redirect("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
